// File: rtl/seg_tube_driver_pkg.sv
// +-----------------------------------------------------------------+
// | tube_pkg : shared constants for the 7-segment tube driver       |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

package tube_pkg;

  localparam int SCAN_IDX_W = 2;

  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Segment bits are {dp,g,f,e,d,c,b,a}; entry n is the pattern for hex digit n.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
    8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

endpackage

`default_nettype wire

// File: rtl/seg_tube_driver_if.sv
// +-----------------------------------------------------------------+
// | seg_tube_driver_if : CPU-side write port and tube outputs       |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

interface seg_tube_driver_if;

  logic        disp_we;
  logic [31:0] disp_data;
  logic        disp_en;
  logic [7:0]  tube_scan;
  logic [7:0]  tube_signal_left;
  logic [7:0]  tube_signal_right;
  logic [31:0] shown_value;

  modport master (
    output disp_we, disp_data, disp_en,
    input  tube_scan, tube_signal_left, tube_signal_right, shown_value
  );

  modport slave (
    input  disp_we, disp_data, disp_en,
    output tube_scan, tube_signal_left, tube_signal_right, shown_value
  );

endinterface

`default_nettype wire

// File: rtl/seg_tube_driver_hex_to_seg7.sv
// +-----------------------------------------------------------------+
// | hex_to_seg7 : combinational nibble to 7-segment pattern decode  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

module hex_to_seg7
  import tube_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [7:0] seg_o
);

  assign seg_o = SEG_TABLE[nibble_i];

endmodule

`default_nettype wire

// File: rtl/seg_tube_driver.sv
// +-----------------------------------------------------------------+
// | seg_tube_driver : 8-digit multiplexed tube, frame double buffer |
// | Optional leading-zero blanking with `define TUBE_LZB_EN         |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

module seg_tube_driver
  import tube_pkg::*;
#(
  parameter int SCAN_DIV = 100_000
) (
  input  logic            clk,
  input  logic            rst,
  seg_tube_driver_if.slave bus
);

  localparam int               CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [SCAN_IDX_W-1:0] k_q, k_d;
  logic [31:0]           pend_q, pend_d;
  logic                  pflag_q, pflag_d;
  logic [31:0]           shown_q, shown_d;
  logic [7:0]            scan_q, scan_d;
  logic [7:0]            left_q, left_d;
  logic [7:0]            right_q, right_d;

  logic       tick;
  logic       boundary;
  logic [2:0] l_idx, r_idx;
  logic [3:0] l_nib, r_nib;
  logic [7:0] l_seg, r_seg;
  logic       l_blank, r_blank;
  logic [3:0] bank_sel;

  assign tick     = (cnt_q == CNT_LAST);
  assign boundary = tick && (k_q == 2'd3);

  // Left bank shows digit 7-k, right bank digit 3-k.
  assign l_idx    = {1'b1, ~k_q};
  assign r_idx    = {1'b0, ~k_q};
  assign l_nib    = shown_q[{l_idx, 2'b00} +: 4];
  assign r_nib    = shown_q[{r_idx, 2'b00} +: 4];
  assign bank_sel = 4'b1000 >> k_q;

  hex_to_seg7 u_seg_left  (.nibble_i(l_nib), .seg_o(l_seg));
  hex_to_seg7 u_seg_right (.nibble_i(r_nib), .seg_o(r_seg));

`ifdef TUBE_LZB_EN
  logic [2:0] top_nz;

  // Digit 0 is never blanked, so the search starts at nibble 1.
  always_comb begin
    top_nz = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (shown_q[4*i +: 4] != 4'h0) top_nz = 3'(i);
    end
  end

  assign l_blank = (l_idx > top_nz);
  assign r_blank = (r_idx > top_nz);
`else
  assign l_blank = 1'b0;
  assign r_blank = 1'b0;
`endif

  always_comb begin
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    k_d     = tick ? k_q + 1'b1 : k_q;
    pend_d  = pend_q;
    pflag_d = pflag_q;
    shown_d = shown_q;
    if (bus.disp_we) begin
      pend_d  = bus.disp_data;
      pflag_d = 1'b1;
    end
    // A write landing on the boundary cycle bypasses the buffer.
    if (boundary) begin
      if (bus.disp_we) shown_d = bus.disp_data;
      else if (pflag_q) shown_d = pend_q;
      pflag_d = 1'b0;
    end
  end

  always_comb begin
    scan_d  = 8'h00;
    left_d  = SEG_BLANK;
    right_d = SEG_BLANK;
    if (bus.disp_en) begin
      scan_d  = {bank_sel, bank_sel};
      left_d  = l_blank ? SEG_BLANK : l_seg;
      right_d = r_blank ? SEG_BLANK : r_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      k_q     <= '0;
      pend_q  <= '0;
      pflag_q <= 1'b0;
      shown_q <= '0;
      scan_q  <= '0;
      left_q  <= '0;
      right_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      pend_q  <= pend_d;
      pflag_q <= pflag_d;
      shown_q <= shown_d;
      scan_q  <= scan_d;
      left_q  <= left_d;
      right_q <= right_d;
    end
  end

  assign bus.tube_scan         = scan_q;
  assign bus.tube_signal_left  = left_q;
  assign bus.tube_signal_right = right_q;
  assign bus.shown_value       = shown_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_tube_driver.sv
// +-----------------------------------------------------------------+
// | tb_seg_tube_driver : self-checking bench, SCAN_DIV = 4          |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

module tb_seg_tube_driver;

  localparam int SCAN_DIV = 4;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg_tube_driver_if bus();

  seg_tube_driver #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] hex_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  // Reference state: position inside the 4*SCAN_DIV frame plus the display buffer contents.
  int          m_ph = 0;
  logic [31:0] m_shown = '0, m_pend = '0;
  bit          m_flag = 1'b0;
  logic [7:0]  m_scan = '0, m_left = '0, m_right = '0;

  function automatic logic [7:0] seg_of(input logic [31:0] v, input int d);
    int top;
    top = 0;
    for (int i = 1; i < 8; i++) if (((v >> (4 * i)) & 32'hF) != 0) top = i;
`ifdef TUBE_LZB_EN
    if (d > top) return 8'h00;
`endif
    return hex_tab[(v >> (4 * d)) & 32'hF];
  endfunction

  task automatic cyc(input logic we, input logic [31:0] d, input logic en, input logic r);
    int k;
    bus.disp_we   = we;
    bus.disp_data = d;
    bus.disp_en   = en;
    rst           = r;
    @(posedge clk);
    if (r) begin
      m_ph = 0; m_shown = '0; m_pend = '0; m_flag = 0;
      m_scan = '0; m_left = '0; m_right = '0;
    end else begin
      k       = m_ph / SCAN_DIV;
      m_scan  = en ? 8'((1 << (7 - k)) | (1 << (3 - k))) : 8'h00;
      m_left  = en ? seg_of(m_shown, 7 - k) : 8'h00;
      m_right = en ? seg_of(m_shown, 3 - k) : 8'h00;
      if (m_ph == FRAME - 1) begin
        if (we) m_shown = d;
        else if (m_flag) m_shown = m_pend;
        if (we) m_pend = d;
        m_flag = 0;
      end else if (we) begin
        m_pend = d;
        m_flag = 1;
      end
      m_ph = (m_ph + 1) % FRAME;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic align(input int ph);
    for (int i = 0; i < 2 * FRAME && m_ph != ph; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 32'h0, 1'b1, 1'b1);
      checks++;
      if ({bus.tube_scan, bus.tube_signal_left, bus.tube_signal_right, bus.shown_value} !== 56'h0) begin
        errors++;
        $display("FAIL reset_outputs: got scan=%h l=%h r=%h shown=%h, want all 0",
                 bus.tube_scan, bus.tube_signal_left, bus.tube_signal_right, bus.shown_value);
      end
    end
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (bus.tube_scan !== 8'h88 || bus.tube_signal_left !== 8'h3F || bus.tube_signal_right !== 8'h3F) begin
      errors++;
      $display("FAIL first_cycle: got scan=%h l=%h r=%h, want 88/3f/3f",
               bus.tube_scan, bus.tube_signal_left, bus.tube_signal_right);
    end
    for (int i = 1; i < 2 * FRAME; i++) begin
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      checks++;
      if ({bus.tube_scan, bus.tube_signal_left, bus.tube_signal_right} !== {m_scan, m_left, m_right}) begin
        errors++;
        $display("FAIL scan_rotate: cycle %0d got scan=%h l=%h r=%h, want %h/%h/%h", i,
                 bus.tube_scan, bus.tube_signal_left, bus.tube_signal_right, m_scan, m_left, m_right);
      end
    end
  endtask

  task automatic test_write();
    align(SCAN_DIV);
    cyc(1'b1, 32'h1234_ABCD, 1'b1, 1'b0);
    for (int i = 0; i < 2 * FRAME && m_ph != 0; i++) begin
      checks++;
      if (bus.shown_value !== 32'h0) begin
        errors++;
        $display("FAIL write_midframe: got shown=%h, want 00000000", bus.shown_value);
      end
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
    end
    checks++;
    if (bus.shown_value !== 32'h1234_ABCD) begin
      errors++;
      $display("FAIL write_boundary: got shown=%h, want 1234abcd", bus.shown_value);
    end
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (bus.tube_scan !== 8'h88 || bus.tube_signal_left !== 8'h06 || bus.tube_signal_right !== 8'h77) begin
      errors++;
      $display("FAIL write_k0: got scan=%h l=%h r=%h, want 88/06/77",
               bus.tube_scan, bus.tube_signal_left, bus.tube_signal_right);
    end
    align(3 * SCAN_DIV);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (bus.tube_scan !== 8'h11 || bus.tube_signal_left !== 8'h66 || bus.tube_signal_right !== 8'h5E) begin
      errors++;
      $display("FAIL write_k3: got scan=%h l=%h r=%h, want 11/66/5e",
               bus.tube_scan, bus.tube_signal_left, bus.tube_signal_right);
    end
  endtask

  task automatic test_last_write_wins();
    align(0);
    cyc(1'b1, 32'h1111_1111, 1'b1, 1'b0);
    cyc(1'b1, 32'h2222_2222, 1'b1, 1'b0);
    for (int i = 0; i < 2 * FRAME && m_ph != 0; i++) begin
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      checks++;
      if (bus.shown_value === 32'h1111_1111) begin
        errors++;
        $display("FAIL coalesce_stale: got shown=%h, want never 11111111", bus.shown_value);
      end
    end
    checks++;
    if (bus.shown_value !== 32'h2222_2222) begin
      errors++;
      $display("FAIL coalesce_final: got shown=%h, want 22222222", bus.shown_value);
    end
    align(FRAME - 1);
    cyc(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    checks++;
    if (bus.shown_value !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL boundary_bypass: got shown=%h, want ffffffff", bus.shown_value);
    end
  endtask

  task automatic test_disable();
    align(2 * SCAN_DIV);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 32'h0, 1'b0, 1'b0);
      checks++;
      if ({bus.tube_scan, bus.tube_signal_left, bus.tube_signal_right} !== 24'h0) begin
        errors++;
        $display("FAIL disable_blank: got scan=%h l=%h r=%h, want 0/0/0",
                 bus.tube_scan, bus.tube_signal_left, bus.tube_signal_right);
      end
    end
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (bus.tube_scan !== 8'h11 || bus.tube_signal_left !== m_left || bus.tube_signal_right !== m_right) begin
      errors++;
      $display("FAIL disable_resume: got scan=%h l=%h r=%h, want 11/%h/%h",
               bus.tube_scan, bus.tube_signal_left, bus.tube_signal_right, m_left, m_right);
    end
  endtask

  task automatic test_rst_mid();
    align(2);
    cyc(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    align(10);
    cyc(1'b0, 32'h0, 1'b1, 1'b1);
    cyc(1'b0, 32'h0, 1'b1, 1'b1);
    checks++;
    if ({bus.tube_scan, bus.tube_signal_left, bus.tube_signal_right, bus.shown_value} !== 56'h0) begin
      errors++;
      $display("FAIL rst_mid: got scan=%h l=%h r=%h shown=%h, want all 0",
               bus.tube_scan, bus.tube_signal_left, bus.tube_signal_right, bus.shown_value);
    end
    for (int i = 0; i < FRAME + 4; i++) begin
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      checks++;
      if (bus.shown_value !== 32'h0) begin
        errors++;
        $display("FAIL rst_discard: got shown=%h, want 00000000", bus.shown_value);
      end
    end
  endtask

  task automatic test_lzb();
    logic [7:0] got_l [4];
    logic [7:0] got_r [4];
    logic [31:0] vals [2] = '{32'h0000_00A5, 32'h0};
`ifdef TUBE_LZB_EN
    logic [7:0] exp_l [2][4] = '{'{8'h00, 8'h00, 8'h00, 8'h00}, '{8'h00, 8'h00, 8'h00, 8'h00}};
    logic [7:0] exp_r [2][4] = '{'{8'h00, 8'h00, 8'h77, 8'h6D}, '{8'h00, 8'h00, 8'h00, 8'h3F}};
`else
    logic [7:0] exp_l [2][4] = '{'{8'h3F, 8'h3F, 8'h3F, 8'h3F}, '{8'h3F, 8'h3F, 8'h3F, 8'h3F}};
    logic [7:0] exp_r [2][4] = '{'{8'h3F, 8'h3F, 8'h77, 8'h6D}, '{8'h3F, 8'h3F, 8'h3F, 8'h3F}};
`endif
    for (int v = 0; v < 2; v++) begin
      align(0);
      cyc(1'b1, vals[v], 1'b1, 1'b0);
      align(0);
      for (int k = 0; k < 4; k++) begin
        align(k * SCAN_DIV);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        got_l[k] = bus.tube_signal_left;
        got_r[k] = bus.tube_signal_right;
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (got_l[k] !== exp_l[v][k] || got_r[k] !== exp_r[v][k]) begin
          errors++;
          $display("FAIL lzb_digits: value %h k=%0d got l=%h r=%h, want %h/%h",
                   vals[v], k, got_l[k], got_r[k], exp_l[v][k], exp_r[v][k]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic en = 1'b1;
    logic we, r;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) en = ~en;
      we = ($urandom_range(0, 5) == 0);
      r  = ($urandom_range(0, 149) == 0);
      cyc(we, $urandom, en, r);
      checks++;
      if ({bus.tube_scan, bus.tube_signal_left, bus.tube_signal_right, bus.shown_value} !==
          {m_scan, m_left, m_right, m_shown}) begin
        errors++;
        $display("FAIL random_model: cycle %0d got %h/%h/%h/%h, want %h/%h/%h/%h", i,
                 bus.tube_scan, bus.tube_signal_left, bus.tube_signal_right, bus.shown_value,
                 m_scan, m_left, m_right, m_shown);
      end
    end
  endtask

  initial begin
    bus.disp_we   = 1'b0;
    bus.disp_data = 32'h0;
    bus.disp_en   = 1'b1;
    test_reset();
    test_write();
    test_last_write_wins();
    test_disable();
    test_rst_mid();
    test_lzb();
    test_random();
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
